// File: rtl/csr_file_pkg.sv
// csr_file_pkg: CSR operation encodings, CSR address map and the read-modify-write helper
// shared by csr_file and its counter sub-module.
package csr_file_pkg;

  typedef enum logic [2:0] {
    CSR_OP_NOP = 3'b000,
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_ADDR_INSTRETH  = 12'hC82;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  // Low two bits of the op select write (01), set (10) or clear (11); bit 2 only picks the operand.
  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] operand);
    case (op)
      CSR_OP_RW, CSR_OP_RWI: return operand;
      CSR_OP_RS, CSR_OP_RSI: return old_val | operand;
      CSR_OP_RC, CSR_OP_RCI: return old_val & ~operand;
      default:               return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit free-running counter whose halves can be loaded independently;
// a load holds the other half and suppresses the increment for that cycle.
module csr_counter64
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] r_value;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (wr_lo) begin
      r_value[31:0] <= wdata;
    end else if (wr_hi) begin
      r_value[63:32] <= wdata;
    end else if (inc) begin
      r_value <= r_value + 64'd1;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR block (mstatus, mtvec, mscratch, mepc, mcause, mhartid) with trap/mret
// handling. Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their shadows.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_wr_en,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_field,
  input  logic [31:0] rs1_data,
  input  logic        instr_retire,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  csr_op_e     w_op;
  logic [31:0] w_operand;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_impl;
  logic        w_write_req;
  logic        w_illegal_req;
  logic        w_csr_we;

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
`else
  logic        w_unused_retire;
  assign w_unused_retire = instr_retire;
`endif

  assign w_op      = csr_op_e'(csr_op);
  assign w_operand = csr_op[2] ? {27'b0, rs1_field} : rs1_data;
  // Set/clear forms with rs1/zimm = 0 are pure reads, so they may target read-only CSRs.
  assign w_write_req = (csr_op[1:0] == 2'b01) || ((csr_op[1:0] != 2'b00) && (rs1_field != 5'd0));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_impl = 1'b1;
    w_old  = '0;
    case (csr_addr)
      CSR_ADDR_MSTATUS: begin
        w_old[MSTATUS_MIE_BIT]  = r_mie;
        w_old[MSTATUS_MPIE_BIT] = r_mpie;
      end
      CSR_ADDR_MTVEC:    w_old = r_mtvec;
      CSR_ADDR_MSCRATCH: w_old = r_mscratch;
      CSR_ADDR_MEPC:     w_old = r_mepc;
      CSR_ADDR_MCAUSE:   w_old = r_mcause;
      CSR_ADDR_MHARTID:  w_old = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_ADDR_MCYCLE,    CSR_ADDR_CYCLE:    w_old = w_mcycle[31:0];
      CSR_ADDR_MCYCLEH,   CSR_ADDR_CYCLEH:   w_old = w_mcycle[63:32];
      CSR_ADDR_MINSTRET,  CSR_ADDR_INSTRET:  w_old = w_minstret[31:0];
      CSR_ADDR_MINSTRETH, CSR_ADDR_INSTRETH: w_old = w_minstret[63:32];
`endif
      default: w_impl = 1'b0;
    endcase
  end

  assign w_new         = csr_apply(w_op, w_old, w_operand);
  assign w_illegal_req = csr_wr_en && (!w_impl || (w_write_req && (csr_addr[11:10] == 2'b11)));
  assign w_csr_we      = csr_wr_en && w_write_req && !w_illegal_req && !trap_en && !mret;

  assign illegal = rst_n && w_illegal_req;
  assign rd_data = (rst_n && csr_wr_en && !w_illegal_req) ? w_old : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= MTVEC_RESET & ALIGN_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else if (trap_en) begin
      r_mepc   <= trap_pc & ALIGN_MASK;
      r_mcause <= trap_cause;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_csr_we) begin
      case (csr_addr)
        CSR_ADDR_MSTATUS: begin
          r_mie  <= w_new[MSTATUS_MIE_BIT];
          r_mpie <= w_new[MSTATUS_MPIE_BIT];
        end
        CSR_ADDR_MTVEC:    r_mtvec    <= w_new & ALIGN_MASK;
        CSR_ADDR_MSCRATCH: r_mscratch <= w_new;
        CSR_ADDR_MEPC:     r_mepc     <= w_new & ALIGN_MASK;
        CSR_ADDR_MCAUSE:   r_mcause   <= w_new;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (w_csr_we && (csr_addr == CSR_ADDR_MCYCLE)),
    .wr_hi (w_csr_we && (csr_addr == CSR_ADDR_MCYCLEH)),
    .wdata (w_new),
    .value (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_retire),
    .wr_lo (w_csr_we && (csr_addr == CSR_ADDR_MINSTRET)),
    .wr_hi (w_csr_we && (csr_addr == CSR_ADDR_MINSTRETH)),
    .wdata (w_new),
    .value (w_minstret)
  );
`endif

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_mie;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter: MTVEC_RESET, 32'h0000_0000, mtvec reset value.
REQ-002 SHALL have parameter: HART_ID, 32'h0000_0000, value read from mhartid.
REQ-003 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port: csr_wr_en  input  1  a CSR instruction is executing this cycle (from cu).
REQ-006 SHALL have port: csr_op  input  3  CSR operation (from cu); encodings NOP=000, RW=001, RS=010, RC=011, RWI=101, RSI=110, RCI=111.
REQ-007 SHALL have port: csr_addr  input  12  CSR address, instruction bits [31:20].
REQ-008 SHALL have port: rs1_field  input  5  instruction bits [19:15]; the zimm for immediate forms.
REQ-009 SHALL have port: rs1_data  input  32  rs1 register value.
REQ-010 SHALL have ports: instr_retire  input  1  one instruction retires this cycle; trap_en  input  1  take trap; trap_pc  input  32  PC of the trapping instruction; trap_cause  input  32  cause code; mret  input  1  MRET executing.
REQ-011 SHALL have ports: rd_data  output  32  old CSR value to rd; illegal  output  1  illegal CSR access; mtvec_o  output  32; mepc_o  output  32; mie_o  output  1.

Function
REQ-012 SHALL drive rd_data combinationally with the pre-write CSR value when csr_wr_en=1, else 0; new value visible next cycle.
REQ-013 SHALL implement: mstatus 0x300 (MIE bit 3, MPIE bit 7 only; rest read 0), mtvec 0x305 (bits [1:0] read 0), mscratch 0x340, mepc 0x341 (bits [1:0] read 0), mcause 0x342, mhartid 0xF14 (reads HART_ID).
REQ-014 SHALL compute the operand as rs1_data for RW/RS/RC and {27'b0, rs1_field} for RWI/RSI/RCI; new = operand (RW*), old|operand (RS*), old&~operand (RC*).
REQ-015 SHALL write for RW/RWI always; for RS/RC/RSI/RCI only when rs1_field != 0.
REQ-016 SHALL assert illegal when csr_wr_en=1 and the address is unimplemented, or a write (per REQ-015) targets addr[11:10]=2'b11; illegal access SHALL change no state and return rd_data=0.
REQ-017 SHALL on trap_en: mepc<=trap_pc with bits [1:0] cleared, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-018 SHALL on mret (trap_en=0): MIE<=MPIE, MPIE<=1.
REQ-019 SHALL give priority trap_en > mret > CSR write in the same cycle; lower-priority actions are dropped.
REQ-020 SHALL continuously drive mtvec_o, mepc_o, mie_o from register state.

Reset
REQ-021 SHALL on rst_n=0 at a clock edge set mtvec=MTVEC_RESET and all other CSRs and counters to 0, with rd_data=0 and illegal=0 held while rst_n=0; reset overrides every simultaneous event.

Configuration
REQ-022 SHALL, with CSR_COUNTERS_EN defined, implement 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), plus read-only shadows cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82.
REQ-023 SHALL increment mcycle every cycle and minstret when instr_retire=1, wrapping 2^64-1 to 0, with carry from low to high half.
REQ-024 SHALL, when either half of a counter is written, load that half, hold the other half, and suppress that counter's increment that cycle.
REQ-025 SHALL, without CSR_COUNTERS_EN, omit counter registers and treat all counter addresses as unimplemented.

Structure
REQ-026 SHALL take the csr_op encodings and CSR address constants from the shared defines header, alongside the existing CSR_* op definitions.
REQ-027 SHALL instantiate sub-module csr_counter64 (clk, rst_n, inc, wr_lo, wr_hi, wdata, value[63:0]) twice when CSR_COUNTERS_EN is defined.

Verification
REQ-028 SHALL cover: CSRRW 0x340 with rs1_data=0xDEADBEEF then CSRRS 0x340 with rs1_field=0 -> rd_data 0 then 0xDEADBEEF; mscratch unchanged by the second op.
REQ-029 SHALL cover: CSRRSI 0x300 with zimm=8 then trap_en with trap_pc=0x103 and cause=11 -> mie_o=1 then 0; mepc_o=0x100; mcause=11; MPIE=1; mret -> mie_o=1.
REQ-030 SHALL cover: CSRRW 0xC00 -> illegal=1, no state change; CSRRS 0xC00 with rs1_field=0 -> legal, returns cycle low.
REQ-031 SHALL cover: CSRRW 0x7C0 -> illegal=1, rd_data=0.
REQ-032 SHALL cover: trap_en and CSRRW 0x341 (rs1_data=0x500) in the same cycle -> mepc equals trap_pc.
REQ-033 SHALL cover (CSR_COUNTERS_EN): write mcycle low=0xFFFFFFFF, high=0 -> two cycles later mcycleh=1; minstret write with instr_retire=1 -> holds written value.
